vend_ctrl: RTL and testbench

Transaction controller for the vending machine. It accumulates inserted coins into a credit register, checks the requested item against its price, and sequences the one-hot item decoder through `item_select`/`end_trans` for a fixed dispense window. It then returns change. It sits between the coin/keypad front end and the item decoder.

---
 rtl/vend_ctrl_if.sv | 37 +++
 rtl/vend_ctrl.sv | 175 +++++++++++++++++
 tb/tb_vend_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_ctrl_if.sv
// -----------------------------------------------------------------------------
// vend_ctrl_if
// Bundle between the coin/keypad front end and the vending transaction
// controller.
//   master modport (front end): drives coin_valid, coin_value, select_valid,
//                               select_in, cancel; observes controller outputs.
//   slave modport (vend_ctrl):  consumes the strobes; drives item_select,
//                               end_trans, credit, change_valid, change_amount,
//                               coin_reject, insufficient, busy.
// -----------------------------------------------------------------------------
interface vend_ctrl_if;
  logic       coin_valid;     // one-cycle coin strobe
  logic [1:0] coin_value;     // 00=5, 01=10, 10=20, 11=50 units
  logic       select_valid;   // one-cycle item request strobe
  logic [1:0] select_in;      // requested item code
  logic       cancel;         // refund request strobe
  logic [1:0] item_select;    // item code presented to the decoder
  logic       end_trans;      // 1 = decoder outputs forced to zero
  logic [7:0] credit;         // current credit
  logic       change_valid;   // one-cycle change strobe
  logic [7:0] change_amount;  // change value, valid with change_valid
  logic       coin_reject;    // one-cycle pulse, coin refused
  logic       insufficient;   // one-cycle pulse, select refused
  logic       busy;           // high while dispensing or returning change

  modport master (
    output coin_valid, coin_value, select_valid, select_in, cancel,
    input  item_select, end_trans, credit, change_valid, change_amount,
           coin_reject, insufficient, busy
  );

  modport slave (
    input  coin_valid, coin_value, select_valid, select_in, cancel,
    output item_select, end_trans, credit, change_valid, change_amount,
           coin_reject, insufficient, busy
  );
endinterface

// File: rtl/vend_ctrl.sv
// -----------------------------------------------------------------------------
// vend_ctrl
// Vending machine transaction controller. Accumulates coins into an 8-bit
// credit, checks an item request against its price, holds the item decoder
// enabled (end_trans low) for DISP_CYCLES cycles, then returns change.
//
// Ports:
//   clk    - single clock, rising edge
//   rst_n  - asynchronous active-low reset
//   bus    - vend_ctrl_if.slave: coin/select/cancel strobes in; item_select,
//            end_trans, credit, change_valid, change_amount, coin_reject,
//            insufficient, busy out (all registered)
//
// Parameters: PRICE_1..PRICE_4 (item prices for codes 00..11), DISP_CYCLES (>=1)
//
// Optional feature macro: VEND_REFUND_EN
//   defined   - cancel in COLLECT refunds the full credit without dispensing
//   undefined - cancel is ignored; credit is released only by a purchase
// -----------------------------------------------------------------------------
module vend_ctrl #(
  parameter int PRICE_1     = 15,
  parameter int PRICE_2     = 25,
  parameter int PRICE_3     = 40,
  parameter int PRICE_4     = 50,
  parameter int DISP_CYCLES = 4
) (
  input logic        clk,
  input logic        rst_n,
  vend_ctrl_if.slave bus
);

  localparam int               CNT_W     = (DISP_CYCLES < 1) ? 1 : $clog2(DISP_CYCLES + 1);
  localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_DISPENSE,
    S_CHANGE
  } state_t;

  state_t           state_q;
  logic [7:0]       credit_q;
  logic [7:0]       price_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       item_q;
  logic             end_trans_q;
  logic             change_valid_q;
  logic [7:0]       change_amount_q;
  logic             coin_reject_q;
  logic             insufficient_q;
  logic             busy_q;

  logic [7:0] coin_units;
  logic [8:0] coin_sum;
  logic       coin_ok;
  logic [7:0] credit_d;   // credit after this cycle's coin (if accepted)
  logic [7:0] sel_price;
  logic       cancel_req;

  always_comb begin
    coin_units = 8'd5;
    case (bus.coin_value)
      2'b00:   coin_units = 8'd5;
      2'b01:   coin_units = 8'd10;
      2'b10:   coin_units = 8'd20;
      default: coin_units = 8'd50;
    endcase
  end

  always_comb begin
    sel_price = 8'(PRICE_1);
    case (bus.select_in)
      2'b00:   sel_price = 8'(PRICE_1);
      2'b01:   sel_price = 8'(PRICE_2);
      2'b10:   sel_price = 8'(PRICE_3);
      default: sel_price = 8'(PRICE_4);
    endcase
  end

  // The 9th sum bit flags a coin that would push credit past 255.
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_units};
  assign coin_ok  = bus.coin_valid && !coin_sum[8] &&
                    ((state_q == S_IDLE) || (state_q == S_COLLECT));
  assign credit_d = coin_ok ? coin_sum[7:0] : credit_q;

`ifdef VEND_REFUND_EN
  assign cancel_req = bus.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      credit_q        <= 8'd0;
      price_q         <= 8'd0;
      cnt_q           <= '0;
      item_q          <= 2'b00;
      end_trans_q     <= 1'b1;
      change_valid_q  <= 1'b0;
      change_amount_q <= 8'd0;
      coin_reject_q   <= 1'b0;
      insufficient_q  <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      // Any coin not accepted this cycle (overflow or wrong state) is refused.
      coin_reject_q  <= bus.coin_valid && !coin_ok;
      insufficient_q <= 1'b0;
      change_valid_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          credit_q <= credit_d;
          if (coin_ok) state_q <= S_COLLECT;
        end

        S_COLLECT: begin
          if (cancel_req) begin
            // Refund includes a coin accepted in the same cycle.
            state_q         <= S_CHANGE;
            change_valid_q  <= 1'b1;
            change_amount_q <= credit_d;
            credit_q        <= 8'd0;
            busy_q          <= 1'b1;
          end else if (bus.select_valid && (credit_q >= sel_price)) begin
            // Price check uses the pre-coin credit, but a same-cycle coin
            // still lands in credit and therefore in the change.
            state_q  <= S_DISPENSE;
            item_q   <= bus.select_in;
            price_q  <= sel_price;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            credit_q <= credit_d;
          end else begin
            credit_q       <= credit_d;
            insufficient_q <= bus.select_valid;
          end
        end

        S_DISPENSE: begin
          // First DISPENSE cycle drops end_trans; after DISP_CYCLES low
          // cycles the change cycle raises it again.
          if (cnt_q == DISP_LAST) begin
            state_q         <= S_CHANGE;
            end_trans_q     <= 1'b1;
            change_valid_q  <= 1'b1;
            change_amount_q <= credit_q - price_q;
            credit_q        <= 8'd0;
          end else begin
            end_trans_q <= 1'b0;
            cnt_q       <= cnt_q + 1'b1;
          end
        end

        S_CHANGE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.item_select   = item_q;
  assign bus.end_trans     = end_trans_q;
  assign bus.credit        = credit_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change_amount = change_amount_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.insufficient  = insufficient_q;
  assign bus.busy          = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vend_ctrl
// Self-checking bench for vend_ctrl with default parameters. A transaction
// level model (running credit, price table, expected change arithmetic)
// predicts every observed value.
// -----------------------------------------------------------------------------
module tb_vend_ctrl;

  localparam int DISP = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  vend_ctrl_if bus();

  vend_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int m_credit = 0;   // model credit

  function automatic int coin_units(input logic [1:0] c);
    case (c)
      2'b00:   return 5;
      2'b01:   return 10;
      2'b10:   return 20;
      default: return 50;
    endcase
  endfunction

  function automatic int price_of(input logic [1:0] s);
    case (s)
      2'b00:   return 15;
      2'b01:   return 25;
      2'b10:   return 40;
      default: return 50;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of strobes; on return the outputs reflect that edge.
  task automatic drive(input logic cv, input logic [1:0] cc, input logic sv,
                       input logic [1:0] sc, input logic cn);
    bus.coin_valid   = cv;
    bus.coin_value   = cc;
    bus.select_valid = sv;
    bus.select_in    = sc;
    bus.cancel       = cn;
    tick();
    bus.coin_valid   = 1'b0;
    bus.select_valid = 1'b0;
    bus.cancel       = 1'b0;
  endtask

  // Insert a coin while collecting; updates the model and reports whether
  // the model expects the coin to be refused.
  task automatic put_coin(input logic [1:0] c, output logic exp_rej);
    int v;
    v = coin_units(c);
    exp_rej = (m_credit + v > 255);
    if (!exp_rej) m_credit += v;
    drive(1'b1, c, 1'b0, 2'b00, 1'b0);
  endtask

  // Observe a dispense window (no judgement here): called after the edge that
  // accepted the select. Bounded so a stuck DUT cannot hang the run.
  task automatic watch_dispense(output int first_low, output int low_cnt,
                                output int chg_idx, output int chg_amt,
                                output int chg_credit, output logic [1:0] item_seen,
                                output int item_var);
    first_low = -1; low_cnt = 0; chg_idx = -1; chg_amt = -1; chg_credit = -1;
    item_seen = bus.item_select; item_var = 0;
    for (int i = 1; i <= DISP + 10; i++) begin
      tick();
      if (bus.end_trans === 1'b0) begin
        if (first_low < 0) begin
          first_low = i;
          item_seen = bus.item_select;
        end else if (bus.item_select !== item_seen) begin
          item_var++;
        end
        low_cnt++;
      end
      if (bus.change_valid === 1'b1) begin
        chg_idx = i; chg_amt = int'(bus.change_amount); chg_credit = int'(bus.credit);
        break;
      end
    end
  endtask

  int fl, lc, ci, ca, cc, iv;
  logic [1:0] is;
  logic rj;

  task automatic test_reset();
    rst_n = 1'b0;
    bus.coin_valid = 1'b0; bus.coin_value = 2'b00; bus.select_valid = 1'b0;
    bus.select_in = 2'b00; bus.cancel = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (bus.end_trans !== 1'b1) begin n_bad++; $display("FAIL reset_end_trans: got %0b want 1", bus.end_trans); end
    n_cmp++; if (bus.item_select !== 2'b00) begin n_bad++; $display("FAIL reset_item_select: got %0d want 0", bus.item_select); end
    n_cmp++; if (bus.credit !== 8'd0) begin n_bad++; $display("FAIL reset_credit: got %0d want 0", bus.credit); end
    n_cmp++; if (bus.change_valid !== 1'b0) begin n_bad++; $display("FAIL reset_change_valid: got %0b want 0", bus.change_valid); end
    n_cmp++; if (bus.change_amount !== 8'd0) begin n_bad++; $display("FAIL reset_change_amount: got %0d want 0", bus.change_amount); end
    n_cmp++; if (bus.coin_reject !== 1'b0) begin n_bad++; $display("FAIL reset_coin_reject: got %0b want 0", bus.coin_reject); end
    n_cmp++; if (bus.insufficient !== 1'b0) begin n_bad++; $display("FAIL reset_insufficient: got %0b want 0", bus.insufficient); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    m_credit = 0;
    $display("txn reset: done");
  endtask

  task automatic test_basic_purchase();
    put_coin(2'b01, rj);
    n_cmp++; if (bus.credit !== 8'(m_credit)) begin n_bad++; $display("FAIL basic_credit1: got %0d want %0d", bus.credit, m_credit); end
    put_coin(2'b01, rj);
    n_cmp++; if (bus.credit !== 8'(m_credit)) begin n_bad++; $display("FAIL basic_credit2: got %0d want %0d", bus.credit, m_credit); end
    drive(1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    n_cmp++; if (bus.busy !== 1'b1 || bus.insufficient !== 1'b0 || bus.end_trans !== 1'b1) begin
      n_bad++; $display("FAIL basic_accept: busy=%0b insuff=%0b end_trans=%0b want 1/0/1", bus.busy, bus.insufficient, bus.end_trans); end
    watch_dispense(fl, lc, ci, ca, cc, is, iv);
    n_cmp++; if (fl !== 1 || lc !== DISP || ci !== DISP + 1) begin
      n_bad++; $display("FAIL basic_window: first_low=%0d low=%0d chg_at=%0d want 1/%0d/%0d", fl, lc, ci, DISP, DISP + 1); end
    n_cmp++; if (is !== 2'b00 || iv !== 0) begin n_bad++; $display("FAIL basic_item: item=%0d var=%0d want 0/0", is, iv); end
    n_cmp++; if (ca !== m_credit - 15 || cc !== 0) begin n_bad++; $display("FAIL basic_change: amt=%0d credit=%0d want %0d/0", ca, cc, m_credit - 15); end
    m_credit = 0;
    tick();
    n_cmp++; if (bus.change_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL basic_idle: change_valid=%0b busy=%0b want 0/0", bus.change_valid, bus.busy); end
    $display("txn basic: coins 10+10 select 0 change %0d", ca);
  endtask

  task automatic test_insufficient();
    put_coin(2'b10, rj);
    drive(1'b0, 2'b00, 1'b1, 2'b11, 1'b0);
    n_cmp++; if (bus.insufficient !== 1'b1 || bus.credit !== 8'(m_credit) || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL insuff_pulse: insuff=%0b credit=%0d busy=%0b want 1/%0d/0", bus.insufficient, bus.credit, bus.busy, m_credit); end
    tick();
    n_cmp++; if (bus.insufficient !== 1'b0) begin n_bad++; $display("FAIL insuff_one_cycle: got %0b want 0", bus.insufficient); end
    put_coin(2'b11, rj);
    drive(1'b0, 2'b00, 1'b1, 2'b11, 1'b0);
    watch_dispense(fl, lc, ci, ca, cc, is, iv);
    n_cmp++; if (fl !== 1 || lc !== DISP || ci !== DISP + 1 || is !== 2'b11 || iv !== 0) begin
      n_bad++; $display("FAIL insuff_dispense: first_low=%0d low=%0d chg_at=%0d item=%0d var=%0d", fl, lc, ci, is, iv); end
    n_cmp++; if (ca !== m_credit - 50) begin n_bad++; $display("FAIL insuff_change: got %0d want %0d", ca, m_credit - 50); end
    m_credit = 0;
    tick();
    $display("txn insufficient: credit 20 refused item 3, then change %0d", ca);
  endtask

  task automatic test_overflow();
    repeat (5) put_coin(2'b11, rj);
    put_coin(2'b01, rj);
    n_cmp++; if (bus.coin_reject !== rj || bus.credit !== 8'(m_credit)) begin
      n_bad++; $display("FAIL ovf_reject: reject=%0b credit=%0d want %0b/%0d", bus.coin_reject, bus.credit, rj, m_credit); end
    tick();
    n_cmp++; if (bus.coin_reject !== 1'b0) begin n_bad++; $display("FAIL ovf_pulse_width: got %0b want 0", bus.coin_reject); end
    put_coin(2'b00, rj);
    n_cmp++; if (bus.coin_reject !== 1'b0 || bus.credit !== 8'd255) begin
      n_bad++; $display("FAIL ovf_fill: reject=%0b credit=%0d want 0/255", bus.coin_reject, bus.credit); end
    drive(1'b0, 2'b00, 1'b1, 2'b11, 1'b0);
    watch_dispense(fl, lc, ci, ca, cc, is, iv);
    n_cmp++; if (ca !== 205 || ci !== DISP + 1) begin n_bad++; $display("FAIL ovf_change: amt=%0d at=%0d want 205/%0d", ca, ci, DISP + 1); end
    m_credit = 0;
    tick();
    $display("txn overflow: 250+10 refused, +5 -> 255, change %0d", ca);
  endtask

  task automatic test_dispense_coin();
    put_coin(2'b01, rj);
    put_coin(2'b01, rj);
    // coin 10 together with select 00 at credit 20
    drive(1'b1, 2'b01, 1'b1, 2'b00, 1'b0);
    m_credit += 10;
    n_cmp++; if (bus.credit !== 8'(m_credit) || bus.coin_reject !== 1'b0) begin
      n_bad++; $display("FAIL dcoin_same_cycle: credit=%0d reject=%0b want %0d/0", bus.credit, bus.coin_reject, m_credit); end
    // coin during the first dispense cycle is refused
    drive(1'b1, 2'b11, 1'b0, 2'b00, 1'b0);
    n_cmp++; if (bus.coin_reject !== 1'b1 || bus.credit !== 8'(m_credit) || bus.end_trans !== 1'b0) begin
      n_bad++; $display("FAIL dcoin_reject: reject=%0b credit=%0d end_trans=%0b want 1/%0d/0", bus.coin_reject, bus.credit, bus.end_trans, m_credit); end
    watch_dispense(fl, lc, ci, ca, cc, is, iv);
    n_cmp++; if (lc !== DISP - 1 || ci !== DISP || ca !== m_credit - 15) begin
      n_bad++; $display("FAIL dcoin_change: low=%0d at=%0d amt=%0d want %0d/%0d/%0d", lc, ci, ca, DISP - 1, DISP, m_credit - 15); end
    m_credit = 0;
    tick();
    $display("txn dispense_coin: change %0d", ca);
  endtask

  task automatic test_refund();
    int cv_seen;
    int low_seen;
    put_coin(2'b10, rj);
    put_coin(2'b01, rj);
    put_coin(2'b00, rj);
    drive(1'b0, 2'b00, 1'b0, 2'b00, 1'b1);
`ifdef VEND_REFUND_EN
    n_cmp++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 8'd35 || bus.credit !== 8'd0 || bus.end_trans !== 1'b1) begin
      n_bad++; $display("FAIL refund_change: valid=%0b amt=%0d credit=%0d end_trans=%0b want 1/35/0/1",
                        bus.change_valid, bus.change_amount, bus.credit, bus.end_trans); end
    tick();
    n_cmp++; if (bus.change_valid !== 1'b0 || bus.busy !== 1'b0 || bus.end_trans !== 1'b1) begin
      n_bad++; $display("FAIL refund_idle: valid=%0b busy=%0b end_trans=%0b want 0/0/1", bus.change_valid, bus.busy, bus.end_trans); end
    m_credit = 0;
    // cancel beats select; same-cycle coin is refunded too
    put_coin(2'b10, rj);
    drive(1'b1, 2'b01, 1'b1, 2'b00, 1'b1);
    n_cmp++; if (bus.change_valid !== 1'b1 || bus.change_amount !== 8'd30 || bus.end_trans !== 1'b1) begin
      n_bad++; $display("FAIL refund_priority: valid=%0b amt=%0d end_trans=%0b want 1/30/1", bus.change_valid, bus.change_amount, bus.end_trans); end
    m_credit = 0;
    low_seen = 0;
    for (int i = 0; i < DISP + 3; i++) begin
      tick();
      if (bus.end_trans !== 1'b1) low_seen++;
    end
    n_cmp++; if (low_seen !== 0) begin n_bad++; $display("FAIL refund_no_dispense: low cycles=%0d want 0", low_seen); end
    $display("txn refund: enabled, change 35 then 30");
`else
    cv_seen = 0;
    for (int i = 0; i < DISP + 4; i++) begin
      if (bus.change_valid === 1'b1) cv_seen++;
      tick();
    end
    n_cmp++; if (cv_seen !== 0 || bus.credit !== 8'(m_credit)) begin
      n_bad++; $display("FAIL refund_ignored: change strobes=%0d credit=%0d want 0/%0d", cv_seen, bus.credit, m_credit); end
    drive(1'b0, 2'b00, 1'b1, 2'b00, 1'b0);
    watch_dispense(fl, lc, ci, ca, cc, is, iv);
    n_cmp++; if (ca !== m_credit - 15) begin n_bad++; $display("FAIL refund_cleanup: got %0d want %0d", ca, m_credit - 15); end
    m_credit = 0;
    tick();
    $display("txn refund: disabled, cancel ignored, change %0d", ca);
`endif
  endtask

  task automatic test_random();
    int ncoins, v, price, exp_chg;
    logic [1:0] c, s;
    logic same_coin, coin_acc;
    for (int t = 0; t < 30; t++) begin
      ncoins = $urandom_range(1, 4);
      for (int k = 0; k < ncoins; k++) begin
        c = 2'($urandom_range(0, 3));
        put_coin(c, rj);
        n_cmp++; if (bus.coin_reject !== rj || bus.credit !== 8'(m_credit)) begin
          n_bad++; $display("FAIL rnd_coin t=%0d: reject=%0b credit=%0d want %0b/%0d", t, bus.coin_reject, bus.credit, rj, m_credit); end
      end
      if ($urandom_range(0, 3) == 0) begin
        $display("txn rnd %0d: coins only, credit %0d", t, m_credit);
        continue;
      end
      s = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      same_coin = 1'($urandom_range(0, 1));
      price = price_of(s);
      v = coin_units(c);
      coin_acc = same_coin && (m_credit + v <= 255);
      drive(same_coin, c, 1'b1, s, 1'b0);
      if (m_credit >= price) begin
        exp_chg = m_credit + (coin_acc ? v : 0) - price;
        n_cmp++; if (bus.insufficient !== 1'b0 || bus.busy !== 1'b1 || bus.coin_reject !== (same_coin && !coin_acc)) begin
          n_bad++; $display("FAIL rnd_accept t=%0d: insuff=%0b busy=%0b reject=%0b", t, bus.insufficient, bus.busy, bus.coin_reject); end
        watch_dispense(fl, lc, ci, ca, cc, is, iv);
        n_cmp++; if (fl !== 1 || lc !== DISP || ci !== DISP + 1 || is !== s || iv !== 0 || ca !== exp_chg || cc !== 0) begin
          n_bad++; $display("FAIL rnd_purchase t=%0d: fl=%0d low=%0d at=%0d item=%0d var=%0d amt=%0d cred=%0d want item %0d amt %0d",
                            t, fl, lc, ci, is, iv, ca, cc, s, exp_chg); end
        tick();
        $display("txn rnd %0d: item %0d price %0d change %0d", t, s, price, exp_chg);
        m_credit = 0;
      end else begin
        if (coin_acc) m_credit += v;
        n_cmp++; if (bus.insufficient !== 1'b1 || bus.credit !== 8'(m_credit) || bus.busy !== 1'b0) begin
          n_bad++; $display("FAIL rnd_insuff t=%0d: insuff=%0b credit=%0d busy=%0b want 1/%0d/0", t, bus.insufficient, bus.credit, bus.busy, m_credit); end
        $display("txn rnd %0d: item %0d refused, credit %0d", t, s, m_credit);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cv_seen;
    put_coin(2'b10, rj);
    put_coin(2'b00, rj);
    drive(1'b0, 2'b00, 1'b1, 2'b01, 1'b0);
    tick();
    tick();
    n_cmp++; if (bus.end_trans !== 1'b0 || bus.item_select !== 2'b01) begin
      n_bad++; $display("FAIL rstmid_pre: end_trans=%0b item=%0d want 0/1", bus.end_trans, bus.item_select); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.end_trans !== 1'b1 || bus.credit !== 8'd0 || bus.item_select !== 2'b00 || bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_async: end_trans=%0b credit=%0d item=%0d busy=%0b want 1/0/0/0",
                        bus.end_trans, bus.credit, bus.item_select, bus.busy); end
    tick();
    rst_n = 1'b1;
    m_credit = 0;
    cv_seen = 0;
    for (int i = 0; i < DISP + 6; i++) begin
      tick();
      if (bus.change_valid === 1'b1) cv_seen++;
    end
    n_cmp++; if (cv_seen !== 0 || bus.credit !== 8'd0 || bus.end_trans !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_after: change strobes=%0d credit=%0d end_trans=%0b want 0/0/1", cv_seen, bus.credit, bus.end_trans); end
    $display("txn reset_mid: dispense aborted");
  endtask

  initial begin
    test_reset();
    test_basic_purchase();
    test_insufficient();
    test_overflow();
    test_dispense_coin();
    test_refund();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
